// File: rtl/jacobi_result_sender_pkg.sv
// Shared Jacobi constants and address helpers.
// Pure declarations; no clocked logic.
// Not applicable: no handshake.
package jacobi_result_sender_pkg;

  localparam int JACOBI_N                 = 8;
  localparam int JACOBI_V_OFFSET          = 64;
  localparam int JACOBI_ADDR_WIDTH        = 7;
  localparam int JACOBI_OUTPUT_WORD_WIDTH = 16;
  // Eigenvalues (N) followed by the eigenvector matrix (N*N).
  localparam int JACOBI_N_OUTPUT_DATA     = JACOBI_N + JACOBI_N * JACOBI_N;

  // Row-major address of diagonal element i of an n x n matrix.
  function automatic int jacobi_diag_index(input int i, input int n);
    return i * n + i;
  endfunction

endpackage

// File: rtl/jacobi_result_sender_if.sv
// Result stream towards the microcontroller.
// Pure wiring; no latency.
// Standard valid/ready: a word moves when out_vld && out_rdy.
interface jacobi_result_sender_if
  import jacobi_result_sender_pkg::*;
#(
  parameter int DATA_WIDTH = JACOBI_OUTPUT_WORD_WIDTH
);

  logic signed [DATA_WIDTH-1:0] out_dat;
  logic                         out_vld;
  logic                         out_rdy;

  modport master (output out_dat, output out_vld, input out_rdy);
  modport slave  (input out_dat, input out_vld, output out_rdy);

endinterface

// File: rtl/jacobi_sync_fifo.sv
// Generic synchronous FIFO with occupancy count, any DEPTH >= 1.
// Pushed word is visible at the head on the cycle after the push edge.
// Push when full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
module jacobi_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  // Head reads as zero when empty so the output never shows stale storage.
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jacobi_result_sender.sv
// Reads eigenvalues then eigenvectors from the Jacobi RAM and streams them out.
// First word valid RAM_LATENCY+2 cycles after start; one word per cycle when the sink is ready.
// Credit-limited prefetch: reads stall when FIFO plus in-flight reads would exceed FIFO_DEPTH.
module jacobi_result_sender
  import jacobi_result_sender_pkg::*;
#(
  parameter int DATA_WIDTH  = JACOBI_OUTPUT_WORD_WIDTH,
  parameter int ADDR_WIDTH  = JACOBI_ADDR_WIDTH,
  parameter int N           = JACOBI_N,
  parameter int V_OFFSET    = JACOBI_V_OFFSET,
  parameter int RAM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i,
  jacobi_result_sender_if.master tx
);

  localparam int IW  = $clog2(N * N);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = $clog2(FIFO_DEPTH + RAM_LATENCY + 2) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_DIAG,
    S_READ_VEC,
    S_DRAIN,
    S_DONE
  } send_state_t;

  send_state_t            state;
  logic [IW-1:0]          idx;
  logic [RAM_LATENCY-1:0] tag_sr;
  logic [FCW-1:0]         fifo_count;
  logic                   fifo_empty;
  logic [DATA_WIDTH-1:0]  fifo_head;
  logic                   push;
  logic                   pop;
  logic [CRW-1:0]         inflight;
  logic [CRW-1:0]         credit_used;
  logic                   can_issue;
  logic                   drained;

  // The oldest tag marks the cycle in which ram_dout_i carries that read's data.
  assign push = tag_sr[RAM_LATENCY-1];
  assign pop  = tx.out_vld && tx.out_rdy;

  assign tx.out_vld = !fifo_empty;
  assign tx.out_dat = $signed(fifo_head);

  jacobi_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (ram_dout_i),
    .pop      (pop),
    .pop_dat  (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Credit check: a pop this cycle frees its slot in time for a new read, which
  // keeps full throughput with FIFO_DEPTH = RAM_LATENCY + 2.
  always_comb begin
    inflight = CRW'(ram_en_o);
    for (int b = 0; b < RAM_LATENCY; b++) begin
      inflight = inflight + CRW'(tag_sr[b]);
    end
    credit_used = CRW'(fifo_count) + inflight - CRW'(pop);
    can_issue   = (credit_used < CRW'(FIFO_DEPTH));
    drained     = (inflight == '0) &&
                  ((fifo_count == '0) || ((fifo_count == FCW'(1)) && pop));
  end

  // Read-valid tag pipeline matching the RAM latency; cleared on reset so
  // data from aborted reads is never captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_sr <= '0;
    end else begin
      tag_sr[0] <= ram_en_o;
      for (int b = 1; b < RAM_LATENCY; b++) begin
        tag_sr[b] <= tag_sr[b-1];
      end
    end
  end

  // Send sequencer: issues the 72 reads in order and reports busy/done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      ram_en_o   <= 1'b0;
      ram_addr_o <= '0;
    end else begin
      ram_en_o <= 1'b0;
      done_o   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state  <= S_READ_DIAG;
            busy_o <= 1'b1;
            idx    <= '0;
          end
        end
        S_READ_DIAG: begin
          if (can_issue) begin
            ram_en_o   <= 1'b1;
            ram_addr_o <= ADDR_WIDTH'(jacobi_diag_index(int'(idx), N));
            if (idx == IW'(N - 1)) begin
              idx   <= '0;
              state <= S_READ_VEC;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_READ_VEC: begin
          if (can_issue) begin
            ram_en_o   <= 1'b1;
            ram_addr_o <= ADDR_WIDTH'(V_OFFSET + int'(idx));
            if (idx == IW'(N * N - 1)) begin
              idx   <= '0;
              state <= S_DRAIN;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drained) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jacobi_result_sender.sv
// Directed bench for jacobi_result_sender: two instances (latency 2/depth 4 and latency 1/depth 3).
// RAM models return data = address, 16'hBEEF when not read.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_jacobi_result_sender;
  import jacobi_result_sender_pkg::*;

  localparam int DW = 16;
  localparam int AW = 7;
  localparam int NW = JACOBI_N_OUTPUT_DATA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_n;
  logic          start_a, busy_a, done_a, ram_en_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_s1_a, ram_dout_a;
  logic          start_b, busy_b, done_b, ram_en_b;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_dout_b;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_seq [$];

  jacobi_result_sender_if #(.DATA_WIDTH(DW)) tx_a ();
  jacobi_result_sender_if #(.DATA_WIDTH(DW)) tx_b ();

  jacobi_result_sender #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N(8), .V_OFFSET(64),
                         .RAM_LATENCY(2), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .ram_en_o(ram_en_a), .ram_addr_o(ram_addr_a), .ram_dout_i(ram_dout_a), .tx(tx_a));

  jacobi_result_sender #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N(8), .V_OFFSET(64),
                         .RAM_LATENCY(1), .FIFO_DEPTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .ram_en_o(ram_en_b), .ram_addr_o(ram_addr_b), .ram_dout_i(ram_dout_b), .tx(tx_b));

  // RAM models: two-stage read for A, single-stage for B.
  always @(posedge clk) begin
    ram_s1_a   <= ram_en_a ? DW'(ram_addr_a) : 16'hBEEF;
    ram_dout_a <= ram_s1_a;
    ram_dout_b <= ram_en_b ? DW'(ram_addr_b) : 16'hBEEF;
  end

  // Observer for instance A.
  logic [AW-1:0] en_addr_q [$];
  logic [DW-1:0] hs_q [$];
  int            hs_cyc_q [$];
  int mon_issued, mon_hs, mon_max_out, mon_first_vld, mon_done_cnt, mon_done_cyc, mon_stab_viol;
  bit            prev_stall;
  logic [DW-1:0] prev_dat;

  always @(negedge clk) begin
    if (ram_en_a === 1'b1) begin
      en_addr_q.push_back(ram_addr_a);
      mon_issued++;
    end
    if (mon_issued - mon_hs > mon_max_out) mon_max_out = mon_issued - mon_hs;
    if (tx_a.out_vld === 1'b1 && mon_first_vld < 0) mon_first_vld = cyc;
    if (prev_stall && (tx_a.out_vld !== 1'b1 || tx_a.out_dat !== prev_dat)) mon_stab_viol++;
    prev_stall = (tx_a.out_vld === 1'b1) && (tx_a.out_rdy === 1'b0);
    prev_dat   = tx_a.out_dat;
    if (tx_a.out_vld === 1'b1 && tx_a.out_rdy === 1'b1) begin
      hs_q.push_back(tx_a.out_dat);
      hs_cyc_q.push_back(cyc);
      mon_hs++;
    end
    if (done_a === 1'b1) begin
      mon_done_cnt++;
      mon_done_cyc = cyc;
    end
  end

  task automatic mon_clear();
    en_addr_q.delete(); hs_q.delete(); hs_cyc_q.delete();
    mon_issued = 0; mon_hs = 0; mon_max_out = 0; mon_first_vld = -1;
    mon_done_cnt = 0; mon_done_cyc = -1; mon_stab_viol = 0; prev_stall = 0;
  endtask

  task automatic start_pulse_a(output int k);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    k = cyc;
  endtask

  // Leaves the caller in the cycle where done_o is high, or flags a timeout.
  task automatic wait_done_a(input int budget, output bit ok);
    int n = 0;
    while (done_a !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (done_a === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    tx_a.out_rdy = 1'b0; tx_b.out_rdy = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({busy_a, done_a, ram_en_a, ram_addr_a, tx_a.out_vld} !== 11'd0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/en/addr/vld = %b, required all 0",
               {busy_a, done_a, ram_en_a, ram_addr_a, tx_a.out_vld});
    end
    checks++;
    if (tx_a.out_dat !== 16'sd0) begin
      errors++; $display("FAIL reset_dat: got %h, required 0000", tx_a.out_dat);
    end
    checks++;
    if ({busy_b, tx_b.out_vld, ram_en_b} !== 3'b000) begin
      errors++; $display("FAIL reset_b: busy/vld/en = %b, required 000", {busy_b, tx_b.out_vld, ram_en_b});
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (busy_a !== 1'b0 || ram_en_a !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b en=%b, required 0 0", busy_a, ram_en_a);
    end
  endtask

  task automatic test_full_rate();
    int k, bad, last;
    bit ok;
    tx_a.out_rdy = 1'b1;
    mon_clear();
    start_pulse_a(k);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL full_busy: busy=%b after start, required 1", busy_a);
    end
    wait_done_a(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_timeout: done_o not seen in 300 cycles"); end
    repeat (5) @(posedge clk); #1;
    checks++;
    if (hs_q.size() != NW) begin
      errors++; $display("FAIL full_count: got %0d words, required %0d", hs_q.size(), NW);
    end
    bad = 0;
    for (int j = 0; j < hs_q.size() && j < NW; j++) if (hs_q[j] !== exp_seq[j]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_order: %0d wrong words, required 0", bad); end
    checks++;
    if (mon_first_vld - k != 4) begin
      errors++; $display("FAIL full_first_vld: offset %0d, required 4", mon_first_vld - k);
    end
    last = (hs_cyc_q.size() > 0) ? hs_cyc_q[hs_cyc_q.size()-1] : -1000;
    checks++;
    if (last - k != 75) begin
      errors++; $display("FAIL full_last_hs: offset %0d, required 75", last - k);
    end
    checks++;
    if (mon_done_cnt != 1 || mon_done_cyc != last + 1) begin
      errors++; $display("FAIL full_done: count %0d at offset %0d, required 1 at %0d",
                         mon_done_cnt, mon_done_cyc - k, last + 1 - k);
    end
    checks++;
    if (en_addr_q.size() != NW || busy_a !== 1'b0) begin
      errors++; $display("FAIL full_reads: %0d reads busy=%b, required %0d reads busy=0",
                         en_addr_q.size(), busy_a, NW);
    end
  endtask

  task automatic test_backpressure_random();
    int k, bad, n, last;
    tx_a.out_rdy = 1'b0;
    mon_clear();
    start_pulse_a(k);
    n = 0;
    while (done_a !== 1'b1 && n < 2000) begin
      @(posedge clk); #1 tx_a.out_rdy = ($urandom_range(0, 9) < 3);
      n++;
    end
    checks++;
    if (done_a !== 1'b1) begin errors++; $display("FAIL rand_timeout: done_o not seen in 2000 cycles"); end
    tx_a.out_rdy = 1'b1;
    repeat (5) @(posedge clk); #1;
    checks++;
    if (hs_q.size() != NW) begin
      errors++; $display("FAIL rand_count: got %0d words, required %0d", hs_q.size(), NW);
    end
    bad = 0;
    for (int j = 0; j < hs_q.size() && j < NW; j++) if (hs_q[j] !== exp_seq[j]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_order: %0d wrong words, required 0", bad); end
    checks++;
    if (mon_stab_viol != 0) begin
      errors++; $display("FAIL rand_stable: %0d stall cycles changed data, required 0", mon_stab_viol);
    end
    checks++;
    if (mon_max_out > 4) begin
      errors++; $display("FAIL rand_credit: outstanding reached %0d, required <= 4", mon_max_out);
    end
    last = (hs_cyc_q.size() > 0) ? hs_cyc_q[hs_cyc_q.size()-1] : -1000;
    checks++;
    if (mon_done_cnt != 1 || mon_done_cyc != last + 1) begin
      errors++; $display("FAIL rand_done: count %0d cycle %0d, required 1 at %0d",
                         mon_done_cnt, mon_done_cyc, last + 1);
    end
  endtask

  task automatic test_stall_fill();
    int k, bad;
    bit ok;
    logic [AW-1:0] want [4];
    want[0] = 7'd0; want[1] = 7'd9; want[2] = 7'd18; want[3] = 7'd27;
    tx_a.out_rdy = 1'b0;
    mon_clear();
    start_pulse_a(k);
    repeat (20) @(posedge clk); #1;
    checks++;
    if (en_addr_q.size() != 4) begin
      errors++; $display("FAIL stall_reads: %0d reads while stalled, required 4", en_addr_q.size());
    end
    bad = 0;
    for (int j = 0; j < en_addr_q.size() && j < 4; j++) if (en_addr_q[j] !== want[j]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_addr: %0d wrong addresses, required 0", bad); end
    checks++;
    if (tx_a.out_vld !== 1'b1 || tx_a.out_dat !== 16'sd0) begin
      errors++; $display("FAIL stall_head: vld=%b dat=%h, required 1 0000", tx_a.out_vld, tx_a.out_dat);
    end
    tx_a.out_rdy = 1'b1;
    wait_done_a(300, ok);
    repeat (3) @(posedge clk); #1;
    bad = 0;
    for (int j = 0; j < hs_q.size() && j < NW; j++) if (hs_q[j] !== exp_seq[j]) bad++;
    checks++;
    if (!ok || hs_q.size() != NW || bad != 0 || mon_done_cnt != 1) begin
      errors++; $display("FAIL stall_resume: ok=%0d words=%0d bad=%0d done=%0d, required 1 %0d 0 1",
                         ok, hs_q.size(), bad, mon_done_cnt, NW);
    end
  endtask

  task automatic test_start_ignored();
    int k, n, bad;
    bit ok;
    tx_a.out_rdy = 1'b1;
    mon_clear();
    start_pulse_a(k);
    n = 0;
    while (mon_hs < 10 && n < 200) begin @(posedge clk); #1; n++; end
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done_a(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ign_timeout: done_o not seen in 300 cycles"); end
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (40) @(posedge clk); #1;
    checks++;
    if (busy_a !== 1'b0 || en_addr_q.size() != NW) begin
      errors++; $display("FAIL ign_restart: busy=%b reads=%0d, required 0 %0d", busy_a, en_addr_q.size(), NW);
    end
    bad = 0;
    for (int j = 0; j < hs_q.size() && j < NW; j++) if (hs_q[j] !== exp_seq[j]) bad++;
    checks++;
    if (hs_q.size() != NW || bad != 0) begin
      errors++; $display("FAIL ign_stream: words=%0d bad=%0d, required %0d 0", hs_q.size(), bad, NW);
    end
    checks++;
    if (mon_done_cnt != 1) begin
      errors++; $display("FAIL ign_done: %0d done pulses, required 1", mon_done_cnt);
    end
  endtask

  task automatic test_abort();
    int k, n, bad;
    bit ok;
    tx_a.out_rdy = 1'b1;
    mon_clear();
    start_pulse_a(k);
    n = 0;
    while (mon_hs < 30 && n < 200) begin @(posedge clk); #1; n++; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy_a, done_a, ram_en_a, ram_addr_a, tx_a.out_vld} !== 11'd0 || tx_a.out_dat !== 16'sd0) begin
      errors++; $display("FAIL abort_outputs: ctrl=%b dat=%h, required all 0",
                         {busy_a, done_a, ram_en_a, ram_addr_a, tx_a.out_vld}, tx_a.out_dat);
    end
    rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    checks++;
    if (mon_done_cnt != 0 || tx_a.out_vld !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: done=%0d vld=%b, required 0 0", mon_done_cnt, tx_a.out_vld);
    end
    mon_clear();
    start_pulse_a(k);
    wait_done_a(300, ok);
    repeat (3) @(posedge clk); #1;
    bad = 0;
    for (int j = 0; j < hs_q.size() && j < NW; j++) if (hs_q[j] !== exp_seq[j]) bad++;
    checks++;
    if (!ok || hs_q.size() != NW || bad != 0) begin
      errors++; $display("FAIL abort_restart: ok=%0d words=%0d bad=%0d, required 1 %0d 0",
                         ok, hs_q.size(), bad, NW);
    end
    checks++;
    if (en_addr_q.size() == 0 || en_addr_q[0] !== 7'd0 || mon_done_cnt != 1) begin
      errors++; $display("FAIL abort_fresh: reads=%0d done=%0d, required first addr 0 and 1 done",
                         en_addr_q.size(), mon_done_cnt);
    end
  endtask

  task automatic test_small_latency();
    int k, first, last, dcnt, dcyc, bad;
    logic [DW-1:0] w [$];
    tx_b.out_rdy = 1'b1;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    k = cyc;
    first = -1; last = -1000; dcnt = 0; dcyc = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx_b.out_vld === 1'b1 && first < 0) first = cyc;
      if (tx_b.out_vld === 1'b1 && tx_b.out_rdy === 1'b1) begin
        w.push_back(tx_b.out_dat);
        last = cyc;
      end
      if (done_b === 1'b1) begin dcnt++; dcyc = cyc; end
    end
    checks++;
    if (first - k != 3) begin
      errors++; $display("FAIL lat1_first_vld: offset %0d, required 3", first - k);
    end
    bad = 0;
    for (int j = 0; j < w.size() && j < NW; j++) if (w[j] !== exp_seq[j]) bad++;
    checks++;
    if (w.size() != NW || bad != 0) begin
      errors++; $display("FAIL lat1_stream: words=%0d bad=%0d, required %0d 0", w.size(), bad, NW);
    end
    checks++;
    if (last - k != 74) begin
      errors++; $display("FAIL lat1_last_hs: offset %0d, required 74", last - k);
    end
    checks++;
    if (dcnt != 1 || dcyc != last + 1) begin
      errors++; $display("FAIL lat1_done: count %0d at %0d, required 1 at %0d", dcnt, dcyc, last + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < JACOBI_N; i++) exp_seq.push_back(DW'(i * 9));
    for (int r = 0; r < JACOBI_N * JACOBI_N; r++) exp_seq.push_back(DW'(JACOBI_V_OFFSET + r));
    mon_clear();
    test_reset();
    test_full_rate();
    test_backpressure_random();
    test_stall_fill();
    test_start_ignored();
    test_abort();
    test_small_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
